// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 16:1 mux: steps the select lines, waits a settle time per
// position, assembles the sampled bits into a word and hands it off with valid/ready.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  output logic [3:0]  mux_select,
  input  logic        mux_data,
  output logic        busy,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  // With no settle time the state after a select change is SAMPLE directly.
  localparam state_t FIRST_STATE = (SETTLE_CYCLES == 32'd0) ? SAMPLE : SETTLE;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [15:0] asm_r;

  function automatic logic [15:0] insert_bit(input logic [15:0] word,
                                             input logic [3:0]  idx,
                                             input logic        bit_val);
    logic [15:0] res;
    res      = word;
    res[idx] = bit_val;
    return res;
  endfunction

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mux_select <= 4'd0;
      word_out   <= 16'h0000;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      cnt_r      <= 4'd0;
      asm_r      <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          mux_select <= 4'd0;
          word_valid <= 1'b0;
          if (start) begin
            state_r <= FIRST_STATE;
            busy    <= 1'b1;
            cnt_r   <= SETTLE_LOAD;
            asm_r   <= 16'h0000;
          end else begin
            busy    <= 1'b0;
          end
        end

        SETTLE: begin
          // Leave on the edge where the count runs out so the sample lands on
          // edge (i+1)*(SETTLE_CYCLES+1).
          if (cnt_r <= 4'd1) begin
            state_r <= SAMPLE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
          end
        end

        SAMPLE: begin
          asm_r <= insert_bit(asm_r, mux_select, mux_data);
          if (mux_select == 4'd15) begin
            word_out   <= insert_bit(asm_r, mux_select, mux_data);
            word_valid <= 1'b1;
            state_r    <= HOLD;
          end else begin
            mux_select <= mux_select + 4'd1;
            cnt_r      <= SETTLE_LOAD;
            state_r    <= FIRST_STATE;
          end
        end

        HOLD: begin
          if (word_valid && word_ready) begin
            word_valid <= 1'b0;
            mux_select <= 4'd0;
            if (cont) begin
              state_r <= FIRST_STATE;
              cnt_r   <= SETTLE_LOAD;
              asm_r   <= 16'h0000;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            state_r <= HOLD;
          end
        end

        default: begin
          state_r    <= IDLE;
          mux_select <= 4'd0;
          word_valid <= 1'b0;
          busy       <= 1'b0;
          cnt_r      <= 4'd0;
          asm_r      <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: one instance with SETTLE_CYCLES=1 and
// one with SETTLE_CYCLES=0, expected words held in a scoreboard queue.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, cont1, ready1, data1, busy1, valid1;
  logic [3:0]  sel1;
  logic [15:0] word1;
  logic start0, cont0, ready0, data0, busy0, valid0;
  logic [3:0]  sel0;
  logic [15:0] word0;

  logic [15:0] pat;
  logic [15:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  assign data1 = pat[sel1];
  assign data0 = pat[sel0];

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1),
    .mux_select(sel1), .mux_data(data1), .busy(busy1),
    .word_out(word1), .word_valid(valid1), .word_ready(ready1)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0),
    .mux_select(sel0), .mux_data(data0), .busy(busy0),
    .word_out(word0), .word_valid(valid0), .word_ready(ready0)
  );

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic start_scan1(input logic [15:0] p, input bit expect_word);
    pat = p;
    if (expect_word) exp_q.push_back(p);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    edge_n = 0;
  endtask

  // Runs the S=1 instance until word_valid; optional start pulses at given edges.
  task automatic wait_valid1(input string name, input int pulse_a, input int pulse_b);
    logic [15:0] exp_w;
    while (!valid1 && edge_n < 200) begin
      checks++;
      if (busy1 !== 1'b1 || sel1 !== 4'(edge_n / 2)) begin
        failures++;
        $display("FAIL %s_scan edge %0d: busy=%b sel=%0d required busy=1 sel=%0d",
                 name, edge_n, busy1, sel1, edge_n / 2);
      end
      start1 = (edge_n + 1 == pulse_a || edge_n + 1 == pulse_b) ? 1'b1 : 1'b0;
      step();
    end
    start1 = 1'b0;
    checks++;
    if (edge_n !== 32 || valid1 !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid_edge: got edge %0d valid=%b required edge 32 valid=1",
               name, edge_n, valid1);
    end
    checks++;
    if (sel1 !== 4'd15) begin
      failures++;
      $display("FAIL %s_sel_hold: got %0d required 15", name, sel1);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_word: scoreboard empty, got %h", name, word1);
    end else begin
      exp_w = exp_q.pop_front();
      if (word1 !== exp_w) begin
        failures++;
        $display("FAIL %s_word: got %h required %h", name, word1, exp_w);
      end
    end
  endtask

  task automatic check_idle1(input string name);
    checks++;
    if (busy1 !== 1'b0 || valid1 !== 1'b0 || sel1 !== 4'd0) begin
      failures++;
      $display("FAIL %s_idle: busy=%b valid=%b sel=%0d required 0/0/0",
               name, busy1, valid1, sel1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 1'b1; cont1 = 1'b1; ready1 = 1'b1;
    start0 = 1'b1; cont0 = 1'b1; ready0 = 1'b1;
    step();
    step();
    start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0;
    start0 = 1'b0; cont0 = 1'b0; ready0 = 1'b0;
    check_idle1("reset");
    checks++;
    if (word1 !== 16'h0000 || word0 !== 16'h0000 || busy0 !== 1'b0 ||
        valid0 !== 1'b0 || sel0 !== 4'd0) begin
      failures++;
      $display("FAIL reset_words: word1=%h word0=%h busy0=%b valid0=%b sel0=%0d required zero",
               word1, word0, busy0, valid0, sel0);
    end
    rst_n = 1'b1;
    step();
    step();
    check_idle1("reset_wait");
  endtask

  task automatic test_basic();
    ready1 = 1'b1;
    start_scan1(16'hA5C3, 1'b1);
    wait_valid1("basic", -1, -1);
    step();
    check_idle1("basic_done");
    checks++;
    if (word1 !== 16'hA5C3) begin
      failures++;
      $display("FAIL basic_word_kept: got %h required a5c3", word1);
    end
  endtask

  task automatic test_settle0();
    logic [15:0] exp_w;
    pat = 16'h8001;
    exp_q.push_back(16'h8001);
    ready0 = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    edge_n = 0;
    while (!valid0 && edge_n < 100) begin
      checks++;
      if (sel0 !== 4'(edge_n) || busy0 !== 1'b1) begin
        failures++;
        $display("FAIL settle0_step edge %0d: sel=%0d busy=%b required sel=%0d busy=1",
                 edge_n, sel0, busy0, edge_n);
      end
      step();
    end
    checks++;
    if (edge_n !== 16 || sel0 !== 4'd15) begin
      failures++;
      $display("FAIL settle0_valid_edge: got edge %0d sel=%0d required edge 16 sel=15",
               edge_n, sel0);
    end
    exp_w = exp_q.pop_front();
    checks++;
    if (word0 !== exp_w) begin
      failures++;
      $display("FAIL settle0_word: got %h required %h", word0, exp_w);
    end
    step();
    checks++;
    if (busy0 !== 1'b0 || valid0 !== 1'b0) begin
      failures++;
      $display("FAIL settle0_done: busy=%b valid=%b required 0/0", busy0, valid0);
    end
  endtask

  task automatic test_backpressure();
    ready1 = 1'b0;
    start_scan1(16'h3C5A, 1'b1);
    wait_valid1("bp", -1, -1);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (valid1 !== 1'b1 || word1 !== 16'h3C5A || sel1 !== 4'd15 || busy1 !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b word=%h sel=%0d busy=%b required 1/3c5a/15/1",
                 k, valid1, word1, sel1, busy1);
      end
    end
    ready1 = 1'b1;
    step();
    check_idle1("bp_transfer");
  endtask

  task automatic test_back_to_back();
    ready1 = 1'b1;
    cont1  = 1'b1;
    start_scan1(16'h1234, 1'b1);
    wait_valid1("cont_first", -1, -1);
    pat = 16'hFEDC;
    exp_q.push_back(16'hFEDC);
    step();
    checks++;
    if (busy1 !== 1'b1 || valid1 !== 1'b0 || sel1 !== 4'd0) begin
      failures++;
      $display("FAIL cont_restart: busy=%b valid=%b sel=%0d required 1/0/0", busy1, valid1, sel1);
    end
    edge_n = 0;
    cont1  = 1'b0;
    wait_valid1("cont_second", -1, -1);
    step();
    check_idle1("cont_done");
  endtask

  task automatic test_reset_mid();
    bit seen;
    ready1 = 1'b1;
    start_scan1(16'h0F0F, 1'b0);
    while (edge_n < 16) step();
    rst_n  = 1'b0;
    start1 = 1'b1;
    step();
    rst_n  = 1'b1;
    start1 = 1'b0;
    check_idle1("midrst");
    checks++;
    if (word1 !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_word: got %h required 0000", word1);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid1 || busy1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midrst_quiet: got activity after reset required none");
    end
    start_scan1(16'h0F0F, 1'b1);
    wait_valid1("midrst_rescan", -1, -1);
    step();
    check_idle1("midrst_rescan_done");
  endtask

  task automatic test_start_ignored();
    int words;
    ready1 = 1'b1;
    start_scan1(16'h5AA5, 1'b1);
    wait_valid1("ign", 3, 10);
    words = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid1) words++;
    end
    checks++;
    if (words !== 0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL ign_single_word: extra valid cycles=%0d busy=%b required 0/0", words, busy1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    pat = 16'h0000;
    rst_n = 1'b0;
    start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0;
    start0 = 1'b0; cont0 = 1'b0; ready0 = 1'b0;
    test_reset();
    test_basic();
    test_settle0();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, is the number of extra cycles select must be stable before mux_data is sampled; the legal range is 0..15.
REQ-002 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  is the reset: synchronous, active-low.
REQ-004 start  input  1  requests one scan; it is sampled only in IDLE.
REQ-005 cont  input  1  requests continuous mode; it is sampled at each completed word handoff.
REQ-006 mux_select  output  4  drives the 16:1 mux select lines.
REQ-007 mux_data  input  1  carries the 16:1 mux output bit.
REQ-008 busy  output  1  is high from scan acceptance until the final handoff with no restart.
REQ-009 word_out  output  16  holds the assembled word; bit i is the value sampled while mux_select=i.
REQ-010 word_valid  output  1  indicates that word_out holds a complete word.
REQ-011 word_ready  input  1  is consumer acceptance; a transfer occurs on an edge where word_valid=1 and word_ready=1.

Function
REQ-012 The FSM SHALL have four states: IDLE, SETTLE, SAMPLE and HOLD.
REQ-013 In IDLE, mux_select SHALL be 0, busy=0 and word_valid=0, and word_out SHALL keep its last value.
REQ-014 IDLE->SETTLE SHALL occur on the edge (edge 0) at which start=1: mux_select<=0, busy<=1, the settle counter is loaded with SETTLE_CYCLES, and the shift register is cleared.
REQ-015 SETTLE SHALL decrement the counter each cycle and move to SAMPLE when the counter is 0; with SETTLE_CYCLES=0, SETTLE is skipped and the first edge after a select change samples.
REQ-016 In SAMPLE, the edge SHALL capture mux_data into bit mux_select of the assembly register.
REQ-017 After the SAMPLE edge for select<15, the block SHALL apply mux_select<=mux_select+1, reload the counter and return to SETTLE.
REQ-018 After the SAMPLE edge for select=15, the block SHALL load word_out with the complete word, set word_valid<=1, go to HOLD, and keep mux_select at 15.
REQ-019 Bit i SHALL be sampled at edge (i+1)*(SETTLE_CYCLES+1), so word_valid rises at edge 16*(SETTLE_CYCLES+1).
REQ-020 In HOLD, word_valid and word_out SHALL remain stable until a transfer edge; there is no timeout.
REQ-021 A transfer edge with cont=0 SHALL set word_valid<=0, busy<=0, mux_select<=0 and go to IDLE.
REQ-022 A transfer edge with cont=1 SHALL set word_valid<=0, mux_select<=0, reload the counter and go to SETTLE with busy held at 1; that edge becomes edge 0 of the next scan.
REQ-023 word_ready while word_valid=0 SHALL be ignored.
REQ-024 start while busy=1 SHALL be ignored, with no restart and no queueing.
REQ-025 cont SHALL have no effect except at the transfer edge.
REQ-026 mux_select SHALL change only on SETTLE/SAMPLE transitions and on entry to IDLE/SETTLE, and never in HOLD.
REQ-027 The 4-bit select counter SHALL never wrap from 15 to 0 inside a scan; the return to 0 occurs only via REQ-021 or REQ-022.
REQ-028 No output SHALL depend combinationally on any input.

Reset
REQ-029 An edge with rst_n=0 SHALL force IDLE, mux_select=0, word_out=16'h0000, word_valid=0, busy=0, counter=0 and assembly register=0.
REQ-030 Reset SHALL take priority over start, word_ready and cont in the same cycle.
REQ-031 Reset mid-scan or in HOLD SHALL discard the partial or pending word; no word_valid pulse follows.
REQ-032 After rst_n returns to 1, the block SHALL wait in IDLE for start.

Verification
REQ-033 Bench mux model returns bit mux_select of 16'hA5C3, SETTLE_CYCLES=1, start pulsed at edge 0, word_ready=1 -> word_valid at edge 32, word_out=16'hA5C3, busy=0 one edge later.
REQ-034 SETTLE_CYCLES=0, pattern 16'h8001 -> word_valid at edge 16, word_out=16'h8001, mux_select stepping 0..15 one per cycle.
REQ-035 Backpressure: word_ready=0 for 5 cycles after word_valid -> word_valid=1, word_out unchanged, mux_select=15 throughout; transfer on the 6th edge -> IDLE.
REQ-036 cont=1 with pattern 16'h1234 then 16'hFEDC -> two words delivered; the second scan starts on the transfer edge; busy stays 1 until the final transfer with cont=0.
REQ-037 rst_n=0 for one edge after bit 7 is sampled -> all outputs zero, no word_valid; a new start yields a complete correct word.
REQ-038 start pulsed at edges 3 and 10 during a scan -> ignored; exactly one word is produced, with timing unchanged.
